// File: rtl/ddr_read_client_pkg.sv
// Shared definitions for the DDR read client and the merger it talks to.
// channel_update is the command payload carried in the low bits of a
// 128-bit command beat: {addr[54:28], stream_length[27:1], wen[0]}.
package ddr_read_client_pkg;

  localparam int unsigned AddrWidth    = 27;
  localparam int unsigned DataWidth    = 128;
  // Response FIFO entry: {first_tag, last_tag, data}.
  localparam int unsigned FifoWidth    = DataWidth + 2;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [AddrWidth-1:0] stream_length;
    logic                 wen;
  } channel_update;

  typedef enum logic [1:0] {
    StIdle,
    StSendCmd,
    StReceive
  } state_e;

  // Zero-extend a command payload to a full command beat.
  function automatic logic [DataWidth-1:0] pack_cmd(input channel_update cmd);
    return {{(DataWidth - $bits(channel_update)){1'b0}}, cmd};
  endfunction

endpackage

// File: rtl/ddr_read_client_axis_fifo.sv
// First-word-fall-through AXI-stream style FIFO.
// Ports:
//   clk_in / rst_in    clock, async active-high reset
//   wr_data_i/wr_en_i  push side (ignored when full)
//   rd_data_o/rd_valid_o/rd_en_i  pop side; rd_data_o valid whenever non-empty
//   full_o             occupancy == DEPTH
//   count_o            current occupancy
//   count_next_o       occupancy after this cycle's push/pop
module axis_fifo #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 130
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     wr_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     rd_valid_o,
  input  logic                     rd_en_i,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   count_next_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push, pop;

  assign full_o       = (count_q == DepthCnt);
  assign rd_valid_o   = (count_q != '0);
  assign rd_data_o    = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

  assign push = wr_en_i & ~full_o;
  assign pop  = rd_en_i & rd_valid_o;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through count_q.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/ddr_read_client.sv
// DDR read client: accepts a (start address, word count) request, issues one
// read command beat to the merger, tags the returning words with first/last
// markers and buffers them in a FIFO that the consumer drains.
// Ports:
//   clk_in, rst_in                 clock, async active-high reset
//   req_*                          request handshake (addr, length)
//   cmd_axis_*                     command beat to merger
//   rsp_axis_*                     read words from merger (no back-pressure;
//                                  rsp_axis_af throttles it instead)
//   out_axis_*                     buffered words to consumer
//   busy_out, done_out, overflow_out  status
module ddr_read_client
  import ddr_read_client_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned AF_SLACK   = 12
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [26:0]          req_addr,
  input  logic [26:0]          req_length,
  input  logic                 req_valid,
  output logic                 req_ready,
  output logic [127:0]         cmd_axis_data,
  output logic                 cmd_axis_tuser,
  output logic                 cmd_axis_valid,
  output logic                 cmd_axis_smallpile,
  input  logic                 cmd_axis_ready,
  input  logic [127:0]         rsp_axis_data,
  input  logic                 rsp_axis_tuser,
  input  logic                 rsp_axis_valid,
  output logic                 rsp_axis_af,
  output logic                 rsp_axis_ready,
  output logic [127:0]         out_axis_data,
  output logic                 out_axis_tuser,
  output logic                 out_axis_last,
  output logic                 out_axis_valid,
  input  logic                 out_axis_ready,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 overflow_out
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] AfThresh = CntW'(FIFO_DEPTH - AF_SLACK);

  state_e      state_q, state_d;
  logic [26:0] addr_q, addr_d;
  logic [26:0] len_q, len_d;
  logic [26:0] rcv_cnt_q, rcv_cnt_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        af_q, af_d;

  logic                 first_beat, last_beat;
  logic                 fifo_push, fifo_full, fifo_valid;
  logic [FifoWidth-1:0] fifo_wr_data, fifo_rd_data;
  logic [CntW-1:0]      fifo_count, fifo_count_next;
  channel_update        cmd;

  assign first_beat   = (rcv_cnt_q == '0);
  assign last_beat    = (rcv_cnt_q == len_q - 27'd1);
  assign fifo_wr_data = {first_beat, last_beat, rsp_axis_data};

  // Command payload is driven from the latched request so it stays stable
  // for as long as the merger withholds cmd_axis_ready.
  assign cmd.addr          = addr_q;
  assign cmd.stream_length = len_q;
  assign cmd.wen           = CMD_READ;
  assign cmd_axis_data     = pack_cmd(cmd);

  assign cmd_axis_smallpile = 1'b0;
  assign rsp_axis_ready     = 1'b1;
  assign rsp_axis_af        = af_q;
  assign busy_out           = (state_q != StIdle);
  assign done_out           = done_q;
  assign overflow_out       = ovf_q;

  assign out_axis_valid = fifo_valid;
  assign out_axis_tuser = fifo_rd_data[129];
  assign out_axis_last  = fifo_rd_data[128];
  assign out_axis_data  = fifo_rd_data[127:0];

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    len_d          = len_q;
    rcv_cnt_d      = rcv_cnt_q;
    ovf_d          = ovf_q;
    fifo_push      = 1'b0;
    req_ready      = 1'b0;
    cmd_axis_valid = 1'b0;
    cmd_axis_tuser = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid && (req_length != '0)) begin
          addr_d    = req_addr;
          len_d     = req_length;
          rcv_cnt_d = '0;
          state_d   = StSendCmd;
        end
        // Nothing is outstanding, so any response beat is spurious.
        if (rsp_axis_valid) ovf_d = 1'b1;
      end
      StSendCmd: begin
        cmd_axis_valid = 1'b1;
        cmd_axis_tuser = 1'b1;
        if (cmd_axis_ready) state_d = StReceive;
        if (rsp_axis_valid) ovf_d = 1'b1;
      end
      StReceive: begin
        if (rsp_axis_valid) begin
          if (fifo_full) ovf_d = 1'b1;
          else           fifo_push = 1'b1;
          // Tag from our own count; a disagreeing merger marker is an error
          // but the word is still kept.
          if (rsp_axis_tuser != first_beat) ovf_d = 1'b1;
          // Dropped beats still count so the burst terminates.
          if (last_beat) begin
            rcv_cnt_d = '0;
            state_d   = StIdle;
          end else begin
            rcv_cnt_d = rcv_cnt_q + 27'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // done is registered so both the zero-length case and the final word
  // acceptance report on the following cycle.
  always_comb begin
    done_d = (state_q == StIdle && req_valid && req_length == '0) ||
             (fifo_valid && out_axis_ready && out_axis_last);
    // Based on next occupancy so the registered flag tracks current occupancy.
    af_d   = (fifo_count_next >= AfThresh);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      len_q     <= '0;
      rcv_cnt_q <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      af_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      rcv_cnt_q <= rcv_cnt_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      af_q      <= af_d;
    end
  end

  axis_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(FifoWidth)
  ) u_fifo (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .wr_data_i   (fifo_wr_data),
    .wr_en_i     (fifo_push),
    .rd_data_o   (fifo_rd_data),
    .rd_valid_o  (fifo_valid),
    .rd_en_i     (out_axis_ready),
    .full_o      (fifo_full),
    .count_o     (fifo_count),
    .count_next_o(fifo_count_next)
  );

endmodule

// File: tb/tb_ddr_read_client.sv
module tb_ddr_read_client;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b1;
  logic [26:0]  req_addr = '0;
  logic [26:0]  req_length = '0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [127:0] cmd_axis_data;
  logic         cmd_axis_tuser;
  logic         cmd_axis_valid;
  logic         cmd_axis_smallpile;
  logic         cmd_axis_ready = 1'b1;
  logic [127:0] rsp_axis_data = '0;
  logic         rsp_axis_tuser = 1'b0;
  logic         rsp_axis_valid = 1'b0;
  logic         rsp_axis_af;
  logic         rsp_axis_ready;
  logic [127:0] out_axis_data;
  logic         out_axis_tuser;
  logic         out_axis_last;
  logic         out_axis_valid;
  logic         out_axis_ready = 1'b1;
  logic         busy_out;
  logic         done_out;
  logic         overflow_out;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk_in = ~clk_in;

  ddr_read_client dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .req_addr          (req_addr),
    .req_length        (req_length),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .cmd_axis_data     (cmd_axis_data),
    .cmd_axis_tuser    (cmd_axis_tuser),
    .cmd_axis_valid    (cmd_axis_valid),
    .cmd_axis_smallpile(cmd_axis_smallpile),
    .cmd_axis_ready    (cmd_axis_ready),
    .rsp_axis_data     (rsp_axis_data),
    .rsp_axis_tuser    (rsp_axis_tuser),
    .rsp_axis_valid    (rsp_axis_valid),
    .rsp_axis_af       (rsp_axis_af),
    .rsp_axis_ready    (rsp_axis_ready),
    .out_axis_data     (out_axis_data),
    .out_axis_tuser    (out_axis_tuser),
    .out_axis_last     (out_axis_last),
    .out_axis_valid    (out_axis_valid),
    .out_axis_ready    (out_axis_ready),
    .busy_out          (busy_out),
    .done_out          (done_out),
    .overflow_out      (overflow_out)
  );

  // Reset-value view: {busy,cmd_valid,out_valid,af,done,ovf,req_ready,rsp_ready,smallpile}
  logic [8:0] rst_view;
  assign rst_view = {busy_out, cmd_axis_valid, out_axis_valid, rsp_axis_af, done_out,
                     overflow_out, req_ready, rsp_axis_ready, cmd_axis_smallpile};

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    step();
    step();
    vec_cnt++;
    if (rst_view !== 9'b000000110) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %b want 000000110", rst_view);
    end
    rst_in = 1'b0;
    step();
    vec_cnt++;
    if ({req_ready, busy_out} !== 2'b10) begin
      err_cnt++;
      $display("FAIL reset_release: req_ready,busy got %b want 10", {req_ready, busy_out});
    end
  endtask

  // Full request with cmd stalled for 'stall' cycles, then lockstep response
  // beats with the consumer always ready.
  task automatic run_request(input logic [26:0] addr, input logic [26:0] len,
                             input logic [127:0] base, input int stall);
    logic [127:0] exp_cmd;
    exp_cmd = {73'b0, addr, len, 1'b0};
    out_axis_ready = 1'b1;
    cmd_axis_ready = 1'b0;
    req_addr = addr;
    req_length = len;
    req_valid = 1'b1;
    #1;
    vec_cnt++;
    if (req_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL req_ready_idle: got %b want 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    for (int k = 0; k <= stall; k++) begin
      cmd_axis_ready = (k == stall);
      vec_cnt++;
      if ({cmd_axis_valid, cmd_axis_tuser, busy_out} !== 3'b111 || cmd_axis_data !== exp_cmd)
      begin
        err_cnt++;
        $display("FAIL cmd_beat[%0d]: got v/u/b=%b data=%h want 111 data=%h", k,
                 {cmd_axis_valid, cmd_axis_tuser, busy_out}, cmd_axis_data, exp_cmd);
      end
      step();
    end
    vec_cnt++;
    if ({cmd_axis_valid, busy_out} !== 2'b01) begin
      err_cnt++;
      $display("FAIL cmd_done: valid,busy got %b want 01", {cmd_axis_valid, busy_out});
    end
    for (int i = 0; i < int'(len); i++) begin
      rsp_axis_valid = 1'b1;
      rsp_axis_data = base + 128'(i);
      rsp_axis_tuser = (i == 0);
      if (i > 0) begin
        vec_cnt++;
        if ({out_axis_valid, out_axis_tuser, out_axis_last} !== {1'b1, (i == 1), 1'b0} ||
            out_axis_data !== base + 128'(i - 1)) begin
          err_cnt++;
          $display("FAIL out_word[%0d]: got vul=%b data=%h want %b data=%h", i - 1,
                   {out_axis_valid, out_axis_tuser, out_axis_last}, out_axis_data,
                   {1'b1, (i == 1), 1'b0}, base + 128'(i - 1));
        end
      end
      step();
    end
    rsp_axis_valid = 1'b0;
    rsp_axis_tuser = 1'b0;
    vec_cnt++;
    if ({out_axis_valid, out_axis_tuser, out_axis_last, busy_out} !==
        {1'b1, (len == 27'd1), 1'b1, 1'b0} || out_axis_data !== base + 128'(len - 27'd1)) begin
      err_cnt++;
      $display("FAIL out_last_word: got vulb=%b data=%h want %b data=%h",
               {out_axis_valid, out_axis_tuser, out_axis_last, busy_out}, out_axis_data,
               {1'b1, (len == 27'd1), 1'b1, 1'b0}, base + 128'(len - 27'd1));
    end
    step();
    vec_cnt++;
    if ({done_out, out_axis_valid} !== 2'b10) begin
      err_cnt++;
      $display("FAIL done_pulse: done,out_valid got %b want 10", {done_out, out_axis_valid});
    end
    step();
    vec_cnt++;
    if (done_out !== 1'b0) begin
      err_cnt++;
      $display("FAIL done_single: got %b want 0", done_out);
    end
  endtask

  task automatic test_basic();
    run_request(27'h100, 27'd4, 128'hA0, 0);
  endtask

  task automatic test_cmd_backpressure();
    run_request(27'h2A5, 27'd2, 128'hBEEF_0000, 10);
  endtask

  task automatic test_len0();
    req_addr = 27'h5;
    req_length = 27'd0;
    req_valid = 1'b1;
    #1;
    vec_cnt++;
    if (req_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL len0_ready: got %b want 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    vec_cnt++;
    if ({done_out, cmd_axis_valid, busy_out} !== 3'b100) begin
      err_cnt++;
      $display("FAIL len0_done: done,cmd_valid,busy got %b want 100",
               {done_out, cmd_axis_valid, busy_out});
    end
    step();
    vec_cnt++;
    if ({done_out, cmd_axis_valid} !== 2'b00) begin
      err_cnt++;
      $display("FAIL len0_after: done,cmd_valid got %b want 00", {done_out, cmd_axis_valid});
    end
  endtask

  task automatic test_almost_full_overflow();
    out_axis_ready = 1'b0;
    cmd_axis_ready = 1'b1;
    req_addr = 27'h40;
    req_length = 27'd64;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    for (int k = 1; k <= 32; k++) begin
      rsp_axis_valid = 1'b1;
      rsp_axis_data = 128'h1000 + 128'(k - 1);
      rsp_axis_tuser = (k == 1);
      step();
      vec_cnt++;
      if ({rsp_axis_af, overflow_out} !== {(k >= 20), 1'b0}) begin
        err_cnt++;
        $display("FAIL af_occ[%0d]: af,ovf got %b want %b", k,
                 {rsp_axis_af, overflow_out}, {(k >= 20), 1'b0});
      end
    end
    // One beat too many: FIFO holds 32.
    rsp_axis_data = 128'h1000 + 128'd32;
    rsp_axis_tuser = 1'b0;
    step();
    rsp_axis_valid = 1'b0;
    step();
    step();
    vec_cnt++;
    if ({overflow_out, out_axis_valid, busy_out} !== 3'b111) begin
      err_cnt++;
      $display("FAIL overflow_set: ovf,out_valid,busy got %b want 111",
               {overflow_out, out_axis_valid, busy_out});
    end
    out_axis_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      vec_cnt++;
      if ({out_axis_valid, out_axis_tuser, out_axis_last} !== {1'b1, (i == 0), 1'b0} ||
          out_axis_data !== 128'h1000 + 128'(i)) begin
        err_cnt++;
        $display("FAIL full_drain[%0d]: got vul=%b data=%h want %b data=%h", i,
                 {out_axis_valid, out_axis_tuser, out_axis_last}, out_axis_data,
                 {1'b1, (i == 0), 1'b0}, 128'h1000 + 128'(i));
      end
      step();
    end
    vec_cnt++;
    if ({out_axis_valid, rsp_axis_af} !== 2'b00) begin
      err_cnt++;
      $display("FAIL drained_empty: out_valid,af got %b want 00", {out_axis_valid, rsp_axis_af});
    end
    for (int j = 33; j < 64; j++) begin
      rsp_axis_valid = 1'b1;
      rsp_axis_data = 128'h1000 + 128'(j);
      step();
      vec_cnt++;
      if ({out_axis_valid, out_axis_tuser, out_axis_last} !== {1'b1, 1'b0, (j == 63)} ||
          out_axis_data !== 128'h1000 + 128'(j)) begin
        err_cnt++;
        $display("FAIL tail_word[%0d]: got vul=%b data=%h want %b data=%h", j,
                 {out_axis_valid, out_axis_tuser, out_axis_last}, out_axis_data,
                 {1'b1, 1'b0, (j == 63)}, 128'h1000 + 128'(j));
      end
    end
    rsp_axis_valid = 1'b0;
    vec_cnt++;
    if (busy_out !== 1'b0) begin
      err_cnt++;
      $display("FAIL burst64_idle: busy got %b want 0", busy_out);
    end
    step();
    vec_cnt++;
    if ({done_out, out_axis_valid, overflow_out} !== 3'b101) begin
      err_cnt++;
      $display("FAIL overflow_sticky: done,out_valid,ovf got %b want 101",
               {done_out, out_axis_valid, overflow_out});
    end
  endtask

  task automatic test_reset_mid_burst();
    out_axis_ready = 1'b0;
    cmd_axis_ready = 1'b1;
    req_addr = 27'h300;
    req_length = 27'd8;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      rsp_axis_valid = 1'b1;
      rsp_axis_data = 128'h3000 + 128'(i);
      rsp_axis_tuser = (i == 0);
      step();
    end
    rsp_axis_valid = 1'b0;
    rsp_axis_tuser = 1'b0;
    vec_cnt++;
    if ({out_axis_valid, busy_out} !== 2'b11) begin
      err_cnt++;
      $display("FAIL midburst_pre: out_valid,busy got %b want 11", {out_axis_valid, busy_out});
    end
    // Assert between edges so only an asynchronous reset can take effect.
    #2;
    rst_in = 1'b1;
    #1;
    vec_cnt++;
    if (rst_view !== 9'b000000110) begin
      err_cnt++;
      $display("FAIL async_reset: got %b want 000000110", rst_view);
    end
    step();
    rst_in = 1'b0;
    step();
    run_request(27'h123, 27'd3, 128'h5000, 0);
  endtask

  task automatic test_back_to_back();
    out_axis_ready = 1'b0;
    cmd_axis_ready = 1'b1;
    req_addr = 27'h10;
    req_length = 27'd3;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      rsp_axis_valid = 1'b1;
      rsp_axis_data = 128'h7000 + 128'(i);
      rsp_axis_tuser = (i == 0);
      step();
    end
    rsp_axis_valid = 1'b0;
    vec_cnt++;
    if ({busy_out, req_ready, out_axis_valid} !== 3'b011) begin
      err_cnt++;
      $display("FAIL b2b_idle_with_data: busy,ready,out_valid got %b want 011",
               {busy_out, req_ready, out_axis_valid});
    end
    req_addr = 27'h20;
    req_length = 27'd2;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      rsp_axis_valid = 1'b1;
      rsp_axis_data = 128'h7003 + 128'(i);
      rsp_axis_tuser = (i == 0);
      step();
    end
    rsp_axis_valid = 1'b0;
    rsp_axis_tuser = 1'b0;
    out_axis_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vec_cnt++;
      if ({out_axis_valid, out_axis_tuser, out_axis_last} !==
          {1'b1, (i == 0 || i == 3), (i == 2 || i == 4)} ||
          out_axis_data !== 128'h7000 + 128'(i)) begin
        err_cnt++;
        $display("FAIL b2b_word[%0d]: got vul=%b data=%h want %b data=%h", i,
                 {out_axis_valid, out_axis_tuser, out_axis_last}, out_axis_data,
                 {1'b1, (i == 0 || i == 3), (i == 2 || i == 4)}, 128'h7000 + 128'(i));
      end
      step();
      vec_cnt++;
      if (done_out !== (i == 2 || i == 4)) begin
        err_cnt++;
        $display("FAIL b2b_done[%0d]: got %b want %b", i, done_out, (i == 2 || i == 4));
      end
    end
  endtask

  task automatic test_tuser_mismatch();
    out_axis_ready = 1'b0;
    cmd_axis_ready = 1'b1;
    req_addr = 27'h30;
    req_length = 27'd2;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    vec_cnt++;
    if (overflow_out !== 1'b0) begin
      err_cnt++;
      $display("FAIL mismatch_pre: ovf got %b want 0", overflow_out);
    end
    rsp_axis_valid = 1'b1;
    rsp_axis_data = 128'h9000;
    rsp_axis_tuser = 1'b0;
    step();
    rsp_axis_data = 128'h9001;
    vec_cnt++;
    if ({overflow_out, out_axis_valid, out_axis_tuser} !== 3'b111 ||
        out_axis_data !== 128'h9000) begin
      err_cnt++;
      $display("FAIL mismatch_flag: ovf,valid,tuser got %b data=%h want 111 data=9000",
               {overflow_out, out_axis_valid, out_axis_tuser}, out_axis_data);
    end
    step();
    rsp_axis_valid = 1'b0;
    out_axis_ready = 1'b1;
    vec_cnt++;
    if ({out_axis_tuser, out_axis_last, busy_out} !== 3'b100) begin
      err_cnt++;
      $display("FAIL mismatch_word0: tuser,last,busy got %b want 100",
               {out_axis_tuser, out_axis_last, busy_out});
    end
    step();
    vec_cnt++;
    if ({out_axis_valid, out_axis_last} !== 2'b11 || out_axis_data !== 128'h9001) begin
      err_cnt++;
      $display("FAIL mismatch_word1: valid,last got %b data=%h want 11 data=9001",
               {out_axis_valid, out_axis_last}, out_axis_data);
    end
    step();
    vec_cnt++;
    if ({done_out, overflow_out} !== 2'b11) begin
      err_cnt++;
      $display("FAIL mismatch_end: done,ovf got %b want 11", {done_out, overflow_out});
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_cmd_backpressure();
    test_len0();
    test_almost_full_overflow();
    test_reset_mid_burst();
    test_back_to_back();
    test_tuser_mismatch();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, vectors=%0d", vec_cnt);
    $fatal(1, "timeout");
  end

endmodule
